// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: FSM state encodings (common to the RX and TX
// state machines), bit-order and FIFO-status constants, default oversampling
// ratio and a 3-input majority helper.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  // One-hot frame states; the TX FSM uses the same encodings.
  typedef enum logic [4:0] {
    IDLE   = 5'b0_0001,
    START  = 5'b0_0010,
    DATA   = 5'b0_0100,
    PARITY = 5'b0_1000,
    STOP   = 5'b1_0000
  } uartState_t;

  // Bit order: BIGEND sends bit7 first, LITTLEEND sends bit0 first.
  localparam logic BIGEND    = 1'b1;
  localparam logic LITTLEEND = 1'b0;

  // FIFO status flag levels.
  localparam logic EMPTY    = 1'b1;
  localparam logic NONEMPTY = 1'b0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// RX deserializer to RX FIFO / status bus.
// master: the deserializer (drives write strobe, data, error pulses, busy).
// slave : the FIFO side (drives the full flag, observes everything else).
interface uart_rx_deserializer_if;
  logic       p_FifoFull_i;
  logic       n_FifoWe_o;
  logic [7:0] RxData_o;
  logic       p_ParityErr_o;
  logic       p_FrameErr_o;
  logic       p_Overrun_o;
  logic       p_RxBusy_o;

  modport master (
    input  p_FifoFull_i,
    output n_FifoWe_o, RxData_o, p_ParityErr_o, p_FrameErr_o, p_Overrun_o, p_RxBusy_o
  );

  modport slave (
    output p_FifoFull_i,
    input  n_FifoWe_o, RxData_o, p_ParityErr_o, p_FrameErr_o, p_Overrun_o, p_RxBusy_o
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit sampler: RX pin synchroniser, oversample counter and 3-sample majority vote.
// Ports: clk/rst; sampleTick (oversample pulse), serialIn (raw pin), clear (hold
// counter at 0); rxS (synchronised line), bitValid/bitValue (decision tick), bitEnd (wrap).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sampleTick,
  input  logic serialIn,
  input  logic clear,
  output logic rxS,
  output logic bitValid,
  output logic bitValue,
  output logic bitEnd
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] syncReg;
  logic [CNT_W-1:0]       sampleCnt;
  logic                   sampleA;
  logic                   sampleB;
  logic                   tickRun;

  assign rxS     = syncReg[SYNC_STAGES-1];
  assign tickRun = sampleTick && !clear;

  // Flops preset to 1 so reset looks like an idle (marking) line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncReg <= '1;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], serialIn};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sampleCnt <= '0;
      sampleA   <= 1'b1;
      sampleB   <= 1'b1;
    end else if (clear) begin
      sampleCnt <= '0;
    end else if (sampleTick) begin
      if (sampleCnt == CNT_LAST) begin
        sampleCnt <= '0;
      end else begin
        sampleCnt <= sampleCnt + 1'b1;
      end
      if (sampleCnt == CNT_PRE) sampleA <= rxS;
      if (sampleCnt == CNT_MID) sampleB <= rxS;
    end
  end

  // Third vote is the live line value on the decision tick itself.
  assign bitValid = tickRun && (sampleCnt == CNT_POST);
  assign bitValue = majority3(sampleA, sampleB, rxS);
  assign bitEnd   = tickRun && (sampleCnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start-bit validation, 8-bit assembly in either bit
// order, optional parity, stop-bit check and one-clk FIFO write per good byte.
// Ports: clk/rst; p_SampleSig_i tick; SerialData_i pin; frame config inputs
// (latched at start); rxIf carries FIFO write/data, error pulses, busy, full flag.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic p_SampleSig_i,
  input  logic SerialData_i,
  input  logic p_BigEnd_i,
  input  logic p_ParityEn_i,
  input  logic p_ParityOdd_i,
  uart_rx_deserializer_if.master rxIf
);

  uartState_t state;
  uartState_t nextState;

  logic       rxS;
  logic       bitValid;
  logic       bitValue;
  logic       bitEnd;
  logic       startDet;
  logic       stopDecide;

  logic       bigEndLat;
  logic       parEnLat;
  logic       parOddLat;
  logic [2:0] bitCnt;
  logic [2:0] dataIdx;
  logic [7:0] dataReg;
  logic       parityErr;
  logic       needHigh;

  logic       weN;
  logic [7:0] rxData;
  logic       parErrPulse;
  logic       frameErrPulse;
  logic       overrunPulse;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .sampleTick(p_SampleSig_i),
    .serialIn  (SerialData_i),
    .clear     (state == IDLE),
    .rxS       (rxS),
    .bitValid  (bitValid),
    .bitValue  (bitValue),
    .bitEnd    (bitEnd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    startDet   = 1'b0;
    stopDecide = 1'b0;
    case (state)
      IDLE: begin
        // needHigh blocks a held-low (break) line from restarting frames.
        if (p_SampleSig_i && !rxS && !needHigh) begin
          nextState = START;
          startDet  = 1'b1;
        end
      end
      START: begin
        if (bitValid && bitValue) begin
          nextState = IDLE;          // glitch, not a real start bit
        end else if (bitEnd) begin
          nextState = DATA;
        end
      end
      DATA: begin
        if (bitEnd && (bitCnt == 3'd7)) begin
          nextState = parEnLat ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bitEnd) nextState = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so the next falling edge is caught promptly.
        if (bitValid) begin
          nextState  = IDLE;
          stopDecide = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign dataIdx = (bigEndLat == BIGEND) ? (3'd7 - bitCnt) : bitCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bigEndLat     <= LITTLEEND;
      parEnLat      <= 1'b0;
      parOddLat     <= 1'b0;
      bitCnt        <= '0;
      dataReg       <= '0;
      parityErr     <= 1'b0;
      needHigh      <= 1'b0;
      weN           <= 1'b1;
      rxData        <= '0;
      parErrPulse   <= 1'b0;
      frameErrPulse <= 1'b0;
      overrunPulse  <= 1'b0;
    end else begin
      weN           <= 1'b1;
      parErrPulse   <= 1'b0;
      frameErrPulse <= 1'b0;
      overrunPulse  <= 1'b0;

      if (startDet) begin
        bigEndLat <= p_BigEnd_i;
        parEnLat  <= p_ParityEn_i;
        parOddLat <= p_ParityOdd_i;
        bitCnt    <= '0;
        parityErr <= 1'b0;
      end

      if (state == DATA) begin
        if (bitValid) dataReg[dataIdx] <= bitValue;
        if (bitEnd)   bitCnt <= bitCnt + 3'd1;
      end

      if ((state == PARITY) && bitValid) begin
        parityErr <= ((^dataReg) ^ bitValue) != parOddLat;
      end

      if ((state == IDLE) && p_SampleSig_i && rxS) begin
        needHigh <= 1'b0;
      end

      if (stopDecide) begin
        if (!bitValue) begin
          frameErrPulse <= 1'b1;
          needHigh      <= 1'b1;
        end else if (rxIf.p_FifoFull_i) begin
          overrunPulse <= 1'b1;
        end else begin
          weN         <= 1'b0;
          rxData      <= dataReg;
          parErrPulse <= parityErr;
        end
      end
    end
  end

  assign rxIf.n_FifoWe_o    = weN;
  assign rxIf.RxData_o      = rxData;
  assign rxIf.p_ParityErr_o = parErrPulse;
  assign rxIf.p_FrameErr_o  = frameErrPulse;
  assign rxIf.p_Overrun_o   = overrunPulse;
  assign rxIf.p_RxBusy_o    = (state != IDLE);

endmodule
